// File: rtl/fifo_tx_serializer.sv
// FIFO-fed UART-style transmitter: pops one word per frame and sends it LSB-first
// between a start bit (0) and a stop bit (1), each bit lasting BAUD_DIV clocks.
module fifo_tx_serializer #(
  parameter int WIDTH    = 16,
  parameter int BAUD_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data_out,
  output logic             fifo_read,
  input  logic             tx_enable,
  output logic             tx_serial,
  output logic             tx_busy,
  output logic             frame_done,
  output logic [15:0]      word_count
);

  localparam int BW = $clog2(BAUD_DIV) + 1;
  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, STOP} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    baud;
  logic [IW-1:0]    bit_idx;
  logic             baud_end;

  assign baud_end = (baud == BAUD_LAST);

  // Outputs are registered with the value the next state calls for, so each
  // output changes on the same edge as the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      baud       <= '0;
      bit_idx    <= '0;
      fifo_read  <= 1'b0;
      tx_serial  <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      word_count <= '0;
    end else begin
      fifo_read  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          if (tx_enable && !fifo_empty) begin
            state     <= REQ;
            fifo_read <= 1'b1;
            tx_busy   <= 1'b1;
          end
        end
        REQ: state <= LOAD;
        LOAD: begin
          shreg     <= fifo_data_out;
          baud      <= '0;
          state     <= START;
          tx_serial <= 1'b0;
        end
        START: begin
          if (baud_end) begin
            baud      <= '0;
            bit_idx   <= '0;
            state     <= DATA;
            tx_serial <= shreg[0];
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud    <= '0;
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + IW'(1);
            if (bit_idx == BIT_LAST) begin
              state      <= STOP;
              tx_serial  <= 1'b1;
              frame_done <= (BAUD_LAST == '0);
            end else begin
              tx_serial <= shreg[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud       <= '0;
            state      <= IDLE;
            tx_busy    <= 1'b0;
            word_count <= word_count + 16'd1;
          end else begin
            baud       <= baud + BW'(1);
            frame_done <= ((baud + BW'(1)) == BAUD_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
